mem_lsu: RTL and testbench

//  Load/store front-end directly upstream of the 1 KB byte-enabled data memory.

---
 rtl/mem_lsu_if.sv | 23 ++
 rtl/mem_lsu.sv | 116 +++++++++++
 tb/tb_mem_lsu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request/response handshake bundle between a load/store issuer and mem_lsu.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store front-end for a byte-enabled data memory: decode, range check, one-cycle access.
// Optional misalignment trap: define MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  mem_lsu_if.slave    bus,
  output logic [31:0] mem_adrs_rd,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byt_en,
  output logic        mem_sign_ext,
  output logic [31:0] mem_adrs_wr,
  output logic [31:0] mem_wr_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [1:0]  size;
  logic [3:0]  be_d;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misalign;
  logic        fault_d;

  logic        we_q;
  logic        fault_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        rsp_fault_q;

  assign accept = (state == IDLE) && bus.req_valid;
  assign size   = bus.req_funct3[1:0];

  always_comb begin
    be_d   = 4'b0000;
    nbytes = 3'd0;
    case (size)
      2'b00:   begin be_d = 4'b0001; nbytes = 3'd1; end
      2'b01:   begin be_d = 4'b0011; nbytes = 3'd2; end
      2'b10:   begin be_d = 4'b1111; nbytes = 3'd4; end
      default: begin be_d = 4'b0000; nbytes = 3'd0; end
    endcase
  end

  // 33-bit sum so an address near 0xFFFF_FFFF cannot wrap back into range.
  assign end_addr = {1'b0, bus.req_addr} + {30'b0, nbytes};

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && bus.req_addr[0]) ||
                    ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault_d = (size == 2'b11) ||
                   (bus.req_we && bus.req_funct3[2]) ||
                   (end_addr > 33'(MEM_DEPTH)) ||
                   misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp_fault_q  <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_byt_en   <= 4'b0000;
      mem_sign_ext <= 1'b0;
    end else if (accept) begin
      we_q         <= bus.req_we;
      fault_q      <= fault_d;
      addr_q       <= bus.req_addr;
      wdata_q      <= bus.req_wdata;
      mem_wr_en    <= bus.req_we && !fault_d;
      mem_byt_en   <= be_d;
      mem_sign_ext <= !bus.req_we && !bus.req_funct3[2];
    end else if (state == ACCESS) begin
      // Memory is driven for exactly this cycle; the read data is sampled at its end.
      mem_wr_en   <= 1'b0;
      mem_byt_en  <= 4'b0000;
      rdata_q     <= (we_q || fault_q) ? 32'h0 : mem_rd_data;
      rsp_fault_q <= fault_q;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign mem_adrs_rd   = addr_q;
  assign mem_adrs_wr   = addr_q;
  assign mem_wr_data   = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a 1 KB byte-lane memory model and a response scoreboard.
module tb_mem_lsu;
  logic        clk;
  logic        rst;
  logic [31:0] mem_adrs_rd;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [3:0]  mem_byt_en;
  logic        mem_sign_ext;
  logic [31:0] mem_adrs_wr;
  logic [31:0] mem_wr_data;

  int tests;
  int fails;

  logic [31:0] sb_rdata[$];
  logic        sb_fault[$];

  logic [7:0] mem [0:1023];

  mem_lsu_if bus();

  mem_lsu #(.MEM_DEPTH(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mem_adrs_rd  (mem_adrs_rd),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_byt_en   (mem_byt_en),
    .mem_sign_ext (mem_sign_ext),
    .mem_adrs_wr  (mem_adrs_wr),
    .mem_wr_data  (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: lanes land at addr..addr+n-1, result low-aligned and optionally sign-extended.
  always_comb begin
    logic [32:0] sa;
    mem_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      sa = {1'b0, mem_adrs_rd} + 33'(i);
      if (mem_byt_en[i] && (sa < 33'd1024)) mem_rd_data[8*i +: 8] = mem[sa[9:0]];
    end
    if (mem_sign_ext && mem_byt_en == 4'b0001) mem_rd_data[31:8]  = {24{mem_rd_data[7]}};
    if (mem_sign_ext && mem_byt_en == 4'b0011) mem_rd_data[31:16] = {16{mem_rd_data[15]}};
  end

  always @(posedge clk) begin
    logic [32:0] wa;
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        wa = {1'b0, mem_adrs_wr} + 33'(i);
        if (mem_byt_en[i] && (wa < 33'd1024)) mem[wa[9:0]] <= mem_wr_data[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},    32'(bus.req_ready), 32'd1);
    check({tag, " rsp_valid"},    32'(bus.rsp_valid), 32'd0);
    check({tag, " rsp_rdata"},    bus.rsp_rdata,      32'd0);
    check({tag, " rsp_fault"},    32'(bus.rsp_fault), 32'd0);
    check({tag, " mem_wr_en"},    32'(mem_wr_en),     32'd0);
    check({tag, " mem_byt_en"},   32'(mem_byt_en),    32'd0);
    check({tag, " mem_sign_ext"}, 32'(mem_sign_ext),  32'd0);
    check({tag, " mem_adrs_wr"},  mem_adrs_wr,        32'd0);
    check({tag, " mem_wr_data"},  mem_wr_data,        32'd0);
  endtask

  // One transaction: accept, ACCESS, RESP (optionally held with a queued next request), consume.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_fault, input int hold);
    logic [31:0] e_rd;
    logic        e_ft;
    sb_rdata.push_back(exp_rdata);
    sb_fault.push_back(exp_fault);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check({tag, " ready in idle"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " ready in access"}, 32'(bus.req_ready), 32'd0);
    check({tag, " valid in access"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " wr_en in access"}, 32'(mem_wr_en), 32'(we && !exp_fault));
    @(posedge clk); #1;
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (hold > 0) begin
      // A new request waits during RESP; it must not be taken until IDLE.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h10;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        check({tag, " held valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " held rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, " held ready"}, 32'(bus.req_ready), 32'd0);
      end
    end
    e_rd = sb_rdata.pop_front();
    e_ft = sb_fault.pop_front();
    check({tag, " rdata"}, bus.rsp_rdata, e_rd);
    check({tag, " fault"}, 32'(bus.rsp_fault), 32'(e_ft));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, " valid dropped"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    txn("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    txn("SB 0x20",  1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0, 1'b0, 0);
    txn("LB 0x20",  1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    txn("LBU 0x20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, 0);
    txn("LH 0x20",  1'b0, 3'b001, 32'h20, 32'h0, 32'h00000080, 1'b0, 0);

    txn("SW 0x3FC", 1'b1, 3'b010, 32'h3FC, 32'h12345678, 32'h0, 1'b0, 0);
    txn("LW 0x3FC", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h12345678, 1'b0, 0);
    txn("LW 0x3FD", 1'b0, 3'b010, 32'h3FD, 32'h0, 32'h0, 1'b1, 0);
    txn("SW 0x3FE", 1'b1, 3'b010, 32'h3FE, 32'hAAAAAAAA, 32'h0, 1'b1, 0);
    txn("LW 0x3FC again", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h12345678, 1'b0, 0);
    txn("LBU 0x3FF", 1'b0, 3'b100, 32'h3FF, 32'h0, 32'h00000012, 1'b0, 0);
    txn("LB 0x400",  1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    txn("LB top",    1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 0);

    txn("load f3=011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    txn("store f3=100", 1'b1, 3'b100, 32'h30, 32'h000000FF, 32'h0, 1'b1, 0);
    txn("LW 0x30",      1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 0);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    txn("LH 0x11", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0);
`else
    txn("LH 0x11", 1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFFADBE, 1'b0, 0);
`endif

    // Held response with a request waiting, then that request accepted exactly once.
    txn("LHU 0x10 hold", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 5);
    txn("LW 0x10 queued", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    @(posedge clk); #1;
    check("no double accept", 32'(bus.req_ready), 32'd1);

    // Reset while a store is in ACCESS: the write must not land.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst-in-access wr_en before", 32'(mem_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst-in-access");
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    txn("LW 0x40 after rst", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
